// File: rtl/aes_round_col_serial.sv
// Column-serial AES-128 round back-end: ShiftRows at capture, then one column per
// cycle through MixColumns and AddRoundKey, with valid/ready handshakes on both sides.

module aes_mix_columns (
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] w_s0, w_s1, w_s2, w_s3;
  assign {w_s0, w_s1, w_s2, w_s3} = i_col;

  // 3*x is computed as xtime(x)^x
  assign o_col[31:24] = xtime(w_s0) ^ xtime(w_s1) ^ w_s1 ^ w_s2 ^ w_s3;
  assign o_col[23:16] = w_s0 ^ xtime(w_s1) ^ xtime(w_s2) ^ w_s2 ^ w_s3;
  assign o_col[15:8]  = w_s0 ^ w_s1 ^ xtime(w_s2) ^ xtime(w_s3) ^ w_s3;
  assign o_col[7:0]   = xtime(w_s0) ^ w_s0 ^ w_s1 ^ w_s2 ^ xtime(w_s3);
endmodule

module aes_round_col_serial #(
  parameter bit BYPASS_LAST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_round_key,
  input  logic         in_last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  state_t       r_state;
  logic [1:0]   r_cnt;
  logic [127:0] r_sr;
  logic [127:0] r_key;
  logic         r_last;
  logic [127:0] r_out;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;

  logic [31:0]  w_col;
  logic [31:0]  w_kcol;
  logic [31:0]  w_mix;
  logic [31:0]  w_res;

  // byte (r,c) lives at [127-8*(4c+r) -: 8]; row r rotates left by r columns
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return t;
  endfunction

  always_comb begin
    w_col  = '0;
    w_kcol = '0;
    for (int c = 0; c < 4; c++) begin
      if (r_cnt == 2'(c)) begin
        w_col  = r_sr[127-32*c -: 32];
        w_kcol = r_key[127-32*c -: 32];
      end
    end
  end

  aes_mix_columns u_mix (
    .i_col (w_col),
    .o_col (w_mix)
  );

  assign w_res = (r_last ? w_col : w_mix) ^ w_kcol;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_key       <= '0;
      r_last      <= 1'b0;
      r_out       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_sr       <= shift_rows(in_state);
            r_key      <= in_round_key;
            r_last     <= in_last_round & BYPASS_LAST;
            r_cnt      <= '0;
            r_state    <= PROC;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        PROC: begin
          for (int c = 0; c < 4; c++) begin
            if (r_cnt == 2'(c)) r_out[127-32*c -: 32] <= w_res;
          end
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          // result held under backpressure; input stays blocked until back in IDLE
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_state = r_out;
  assign busy      = r_busy;
endmodule

// File: tb/tb_aes_round_col_serial.sv
// Directed bench for aes_round_col_serial: vector table plus backpressure,
// input-isolation and mid-operation reset sequences.

module tb_aes_round_col_serial;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_round_key;
  logic         in_last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic         last;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[5];

  aes_round_col_serial #(.BYPASS_LAST(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_state      (in_state),
    .in_round_key  (in_round_key),
    .in_last_round (in_last_round),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_state     (out_state),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // counts edges until out_valid, bounded
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  task automatic run_vec(input int i);
    int lat;
    in_valid      = 1'b1;
    in_state      = vecs[i].st;
    in_round_key  = vecs[i].key;
    in_last_round = vecs[i].last;
    check($sformatf("v%0d in_ready_idle", i), 128'(in_ready), 128'(1));
    step();
    in_valid     = 1'b0;
    in_state     = {4{$urandom}};
    in_round_key = {4{$urandom}};
    check($sformatf("v%0d busy_proc", i), 128'(busy), 128'(1));
    wait_out(lat);
    check($sformatf("v%0d latency", i), 128'(lat), 128'(4));
    check($sformatf("v%0d out_state", i), out_state, vecs[i].exp);
    step();
    check($sformatf("v%0d valid_one_cycle", i), 128'(out_valid), 128'(0));
    check($sformatf("v%0d in_ready_back", i), 128'(in_ready), 128'(1));
  endtask

  initial begin
    int lat;
    int seen;
    vecs[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605,
                1'b0, 128'ha49c7ff2689f352b6b5bea43026a5049};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h0,
                1'b1, 128'h00050a0f04090e03080d02070c01060b};
    vecs[2] = '{{4{32'hdb135345}}, 128'h0, 1'b0, {4{32'h8e4da1bc}}};
    vecs[3] = '{{4{32'hd4d4d4d5}}, 128'h0, 1'b0, {4{32'hd5d5d7d6}}};
    vecs[4] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605,
                1'b1, 128'h7445a32768e07e1f9be228c8344beee0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_last_round = 1'b0;
    in_state = '0; in_round_key = '0;
    step(); step();
    rst_n = 1'b1;
    check("rst in_ready", 128'(in_ready), 128'(1));
    check("rst out_valid", 128'(out_valid), 128'(0));
    check("rst busy", 128'(busy), 128'(0));
    check("rst out_state", out_state, 128'h0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // backpressure: block B waits at the input while A is held
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = vecs[0].st; in_round_key = vecs[0].key; in_last_round = 1'b0;
    step();
    in_state = vecs[2].st; in_round_key = vecs[2].key;
    wait_out(lat);
    check("bp latency", 128'(lat), 128'(4));
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp hold state %0d", k), out_state, vecs[0].exp);
      check($sformatf("bp in_ready %0d", k), 128'(in_ready), 128'(0));
      check($sformatf("bp out_valid %0d", k), 128'(out_valid), 128'(1));
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp idle out_valid", 128'(out_valid), 128'(0));
    check("bp idle in_ready", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    check("bp second accept", 128'(in_ready), 128'(0));
    wait_out(lat);
    check("bp B latency", 128'(lat), 128'(4));
    check("bp B out_state", out_state, vecs[2].exp);
    step();
    check("bp B drop", 128'(out_valid), 128'(0));

    // input isolation: garbage on the input throughout PROC
    in_valid = 1'b1; in_state = vecs[0].st; in_round_key = vecs[0].key; in_last_round = 1'b0;
    step();
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_state = {4{$urandom}}; in_round_key = {4{$urandom}}; in_last_round = 1'b1;
      check($sformatf("iso in_ready %0d", lat), 128'(in_ready), 128'(0));
      step();
      lat++;
    end
    in_valid = 1'b0;
    check("iso latency", 128'(lat), 128'(4));
    check("iso out_state", out_state, vecs[0].exp);
    step();

    // reset at PROC k=2
    in_valid = 1'b1; in_state = vecs[0].st; in_round_key = vecs[0].key; in_last_round = 1'b0;
    step();
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_mid out_valid", 128'(out_valid), 128'(0));
    check("rst_mid out_state", out_state, 128'h0);
    check("rst_mid in_ready", 128'(in_ready), 128'(1));
    check("rst_mid busy", 128'(busy), 128'(0));
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen++;
      step();
    end
    check("rst_mid no emit", 128'(seen), 128'(0));
    run_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
